ram_stream_ctrl: RTL and testbench
==================================

RAM_STREAM_CTRL -- requirements
Module: ram_stream_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, sample and RAM data width in bits.
REQ-002 Parameter ADDR_W, default 26, RAM word-address width.
REQ-003 Parameter RD_TIMEOUT, default 255, maximum cycles to wait for read data before aborting a read.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 mode  in  2  00 idle, 01 record, 10 playback, 11 loop-playback; sampled only in ST_IDLE.
REQ-008 start_addr  in  ADDR_W  first address of the region; sampled only in ST_IDLE.
REQ-009 end_addr  in  ADDR_W  last address of the region, inclusive; sampled only in ST_IDLE.
REQ-010 wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_W  record sample stream.
REQ-011 rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_W  playback sample stream.
REQ-012 ram_rdy  in  1  RAM controller ready.
REQ-013 ram_addr / ram_din / ram_we  out / out / out  ADDR_W / DATA_W / 1  write port.
REQ-014 ram_rd_req / ram_dout / ram_rd_pres / ram_rd_ack  out / in / in / out  1 / DATA_W / 1 / 1  read port.
REQ-015 busy / done / timeout_err  out / out / out  1 / 1 / 1  status.

Function
REQ-016 States SHALL be ST_IDLE, ST_WR, ST_RD_REQ, ST_RD_WAIT, ST_RD_OUT, ST_DONE; no state advances while ram_rdy=0.
REQ-017 In ST_IDLE with mode!=00 and start_addr<=end_addr: latch region, ptr<=start_addr, busy<=1, go to ST_WR (record) or ST_RD_REQ (playback/loop).
REQ-018 start_addr>end_addr SHALL be ignored: stay in ST_IDLE and pulse done for one cycle.
REQ-019 ST_WR: wr_ready=ram_rdy; on wr_valid&wr_ready drive ram_we=1 for exactly one cycle with ram_addr=ptr, ram_din=wr_data.
REQ-020 After a write at ptr=end_addr, go to ST_DONE; otherwise ptr<=ptr+1 and stay in ST_WR.
REQ-021 ST_RD_REQ: ram_rd_req=1 for one cycle with ram_addr=ptr; then go to ST_RD_WAIT and clear the timeout counter.
REQ-022 ST_RD_WAIT: on ram_rd_pres, capture ram_dout into rd_data, pulse ram_rd_ack for one cycle, go to ST_RD_OUT.
REQ-023 ST_RD_WAIT: if the counter reaches RD_TIMEOUT, set timeout_err (sticky until the next start) and go to ST_DONE.
REQ-024 ST_RD_OUT: rd_valid=1 and rd_data held stable until rd_ready; only one outstanding RAM read at a time.
REQ-025 After the ST_RD_OUT handshake, if ptr=end_addr: playback goes to ST_DONE, loop goes to ST_RD_REQ with ptr<=start_addr; otherwise ptr<=ptr+1 and go to ST_RD_REQ.
REQ-026 mode=00 observed in any non-idle state SHALL abort after the current RAM transaction and handshake complete, then go to ST_DONE.
REQ-027 ST_DONE: done=1 and busy=0 for one cycle, then go to ST_IDLE.
REQ-028 ptr arithmetic SHALL be ADDR_W wide and unsigned; end_addr = 2^ADDR_W-1 SHALL not overflow into a new write.
REQ-029 A write-then-read round trip (record then playback of the same region) SHALL return identical data.

Reset
REQ-030 reset_n low SHALL immediately force state to ST_IDLE, ptr to 0, and all outputs to 0, including rd_data, ram_addr, and ram_din.
REQ-031 Reset mid-transaction SHALL drop ram_we and ram_rd_req without completing the transaction; no ack is issued.

Structure
REQ-032 State encodings and the mode codes SHALL live in the shared package ram_stream_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the RAM wrapper is instantiated by the parent.

Verification
REQ-034 Record region 0x10..0x13 with samples A1,B2,C3,D4 -> four ram_we pulses at addr 0x10..0x13, then one done pulse.
REQ-035 Playback 0x10..0x13 with a 3-cycle ram_rd_pres latency -> rd_data sequence A1,B2,C3,D4, one ram_rd_ack per word, then done.
REQ-036 Loop-playback 0x10..0x11, then mode=00 after 5 samples -> sequence A1,B2,A1,B2,A1, then done after the 5th handshake.
REQ-037 Hold ram_rd_pres low with RD_TIMEOUT=8 -> timeout_err=1 and done 9 cycles after ram_rd_req.
REQ-038 Drop ram_rdy for 4 cycles mid-record and hold rd_ready low for 6 cycles mid-playback -> no lost or duplicated samples, and ptr frozen during each stall.
REQ-039 Assert reset_n low during ST_RD_WAIT -> all outputs 0 immediately, then a fresh record of 1 word succeeds.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM sample-stream controller.
//   - FSM state encodings (ST_*)
//   - host mode codes (MODE_*)
package ram_stream_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD_REQ  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_RD_OUT  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_REC  = 2'b01;
  localparam logic [1:0] MODE_PLAY = 2'b10;
  localparam logic [1:0] MODE_LOOP = 2'b11;

endpackage

// File: rtl/ram_stream_ctrl.sv
// Streams samples between a valid/ready interface and a word-addressed RAM.
// Record writes an inclusive address region from the wr_* stream; playback
// reads the region out on the rd_* stream, optionally looping.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   mode, start_addr, end_addr        command, sampled only while idle
//   wr_valid/wr_ready/wr_data         record sample stream (in)
//   rd_valid/rd_ready/rd_data         playback sample stream (out)
//   ram_rdy                           RAM controller ready; stalls the FSM when low
//   ram_addr/ram_din/ram_we           RAM write port (one-cycle write pulse)
//   ram_rd_req/ram_dout/ram_rd_pres/ram_rd_ack  RAM read port
//   busy, done, timeout_err           status
module ram_stream_ctrl
  import ram_stream_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              ram_rdy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_rd_req,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_rd_pres,
  output logic              ram_rd_ack,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              loop_q, loop_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_rd_req_q, ram_rd_req_d;
  logic              ram_rd_ack_q, ram_rd_ack_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  logic abort_now;
  logic finish;

  // Stream handshakes only open while the RAM side can make progress, so a
  // stall never lets a sample be consumed without the FSM moving with it.
  assign wr_ready = (state_q == ST_WR) && ram_rdy;
  assign rd_valid = (state_q == ST_RD_OUT) && ram_rdy;

  // A stop request seen earlier, or being seen right now.
  assign abort_now = abort_q || (mode == MODE_IDLE);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    start_d      = start_q;
    end_d        = end_q;
    loop_d       = loop_q;
    abort_d      = abort_q;
    cnt_d        = cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_we_d     = 1'b0;
    ram_rd_req_d = 1'b0;
    ram_rd_ack_d = 1'b0;
    rd_data_d    = rd_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    finish       = 1'b0;

    if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (mode == MODE_IDLE)) begin
      abort_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ram_rdy && (mode != MODE_IDLE)) begin
          if (start_addr <= end_addr) begin
            start_d   = start_addr;
            end_d     = end_addr;
            loop_d    = (mode == MODE_LOOP);
            ptr_d     = start_addr;
            busy_d    = 1'b1;
            timeout_d = 1'b0;
            abort_d   = 1'b0;
            state_d   = (mode == MODE_REC) ? ST_WR : ST_RD_REQ;
          end else begin
            // Empty region: acknowledge with done but never leave idle.
            done_d = 1'b1;
          end
        end
      end

      ST_WR: begin
        if (ram_rdy) begin
          if (wr_valid) begin
            ram_we_d   = 1'b1;
            ram_addr_d = ptr_q;
            ram_din_d  = wr_data;
            // Compare before incrementing so the top address never wraps.
            if ((ptr_q == end_q) || abort_now) begin
              finish = 1'b1;
            end else begin
              ptr_d = ptr_q + ADDR_W'(1);
            end
          end else if (abort_now) begin
            finish = 1'b1;
          end
        end
      end

      ST_RD_REQ: begin
        if (ram_rdy) begin
          if (abort_now) begin
            finish = 1'b1;
          end else begin
            ram_rd_req_d = 1'b1;
            ram_addr_d   = ptr_q;
            cnt_d        = '0;
            state_d      = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        if (ram_rdy) begin
          if (ram_rd_pres) begin
            rd_data_d    = ram_dout;
            ram_rd_ack_d = 1'b1;
            state_d      = ST_RD_OUT;
          end else if (cnt_q == CNT_W'(RD_TIMEOUT)) begin
            timeout_d = 1'b1;
            finish    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RD_OUT: begin
        if (rd_valid && rd_ready) begin
          if (ptr_q == end_q) begin
            if (loop_q && !abort_now) begin
              ptr_d   = start_q;
              state_d = ST_RD_REQ;
            end else begin
              finish = 1'b1;
            end
          end else if (abort_now) begin
            finish = 1'b1;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = ST_RD_REQ;
          end
        end
      end

      ST_DONE: begin
        // A RAM stall freezes the FSM here too, so done stays up with it.
        if (ram_rdy) begin
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      start_q      <= '0;
      end_q        <= '0;
      loop_q       <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      ram_rd_req_q <= 1'b0;
      ram_rd_ack_q <= 1'b0;
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      start_q      <= start_d;
      end_q        <= end_d;
      loop_q       <= loop_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
      ram_rd_req_q <= ram_rd_req_d;
      ram_rd_ack_q <= ram_rd_ack_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;
  assign ram_rd_req  = ram_rd_req_q;
  assign ram_rd_ack  = ram_rd_ack_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Self-checking bench for ram_stream_ctrl: a behavioural RAM responder, a
// negedge monitor logging writes/reads/pulses, and an expected-data model.
module tb_ram_stream_ctrl;
  import ram_stream_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned RD_TO  = 8;

  logic              clk;
  logic              reset_n;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              ram_rdy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we, ram_rd_req, ram_rd_pres, ram_rd_ack;
  logic [DATA_W-1:0] ram_dout;
  logic              busy, done, timeout_err;

  ram_stream_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .RD_TIMEOUT(RD_TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .ram_rdy    (ram_rdy),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_rd_req (ram_rd_req),
    .ram_dout   (ram_dout),
    .ram_rd_pres(ram_rd_pres),
    .ram_rd_ack (ram_rd_ack),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state: RAM contents as the DUT wrote them, and what the bench meant to write.
  logic [DATA_W-1:0] mem     [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] src[$];
  logic [DATA_W-1:0] exp_rd[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  logic [DATA_W-1:0] rd_log[$];
  int req_cnt, ack_cnt, done_cnt;
  int cyc_no, last_req_cyc, last_done_cyc;

  // Stimulus knobs.
  int rd_lat    = 3;
  bit rsp_block = 1'b0;
  int rdy_at = 0, rdy_len = 0;
  int rr_at = 0, rr_len = 0;
  bit rr_rand = 1'b0;

  always @(posedge clk) cyc_no++;

  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_we) begin
        wr_addr_log.push_back(ram_addr);
        wr_data_log.push_back(ram_din);
        mem[ram_addr] = ram_din;
      end
      if (rd_valid && rd_ready) rd_log.push_back(rd_data);
      if (ram_rd_req) begin
        req_cnt++;
        last_req_cyc = cyc_no;
      end
      if (ram_rd_ack) ack_cnt++;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc_no;
      end
    end
  end

  // RAM read responder: ram_rd_pres rises rd_lat cycles after ram_rd_req and
  // stays up until the controller acknowledges.
  initial begin
    logic [ADDR_W-1:0] rsp_addr;
    bit pend;
    int wait_n;
    ram_rd_pres = 1'b0;
    ram_dout    = '0;
    pend        = 1'b0;
    wait_n      = 0;
    rsp_addr    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        ram_rd_pres = 1'b0;
        pend        = 1'b0;
      end else begin
        if (ram_rd_ack) ram_rd_pres = 1'b0;
        if (pend) begin
          wait_n--;
          if (wait_n <= 0) begin
            ram_rd_pres = 1'b1;
            ram_dout    = mem.exists(rsp_addr) ? mem[rsp_addr] : '0;
            pend        = 1'b0;
          end
        end
        if (ram_rd_req && !rsp_block) begin
          pend     = 1'b1;
          wait_n   = rd_lat;
          rsp_addr = ram_addr;
        end
      end
    end
  end

  task automatic prep_rec(input logic [ADDR_W-1:0] s, input int n);
    logic [DATA_W-1:0] d;
    src.delete();
    for (int i = 0; i < n; i++) begin
      d = DATA_W'($urandom);
      src.push_back(d);
      ref_mem[s + ADDR_W'(i)] = d;
    end
  endtask

  // Expected playback: k-th sample comes from start + (k mod region length).
  task automatic fill_exp(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e, input int n);
    longint len;
    logic [ADDR_W-1:0] a;
    len = longint'(e - s) + 1;
    exp_rd.delete();
    for (int k = 0; k < n; k++) begin
      a = s + ADDR_W'(longint'(k) % len);
      exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : '0);
    end
  endtask

  task automatic session(input logic [1:0] md, input logic [ADDR_W-1:0] s,
                         input logic [ADDR_W-1:0] e, input int abort_after, input int budget);
    int cyc, hs, widx;
    bit wr_hs, rd_hs, seen;
    logic [ADDR_W-1:0] snap;
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_log.delete();
    req_cnt = 0;
    ack_cnt = 0;
    done_cnt = 0;
    cyc = 0; hs = 0; widx = 0; seen = 1'b0; snap = '0;
    @(posedge clk);
    #1;
    mode = md;
    start_addr = s;
    end_addr = e;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      wr_hs = wr_valid && wr_ready;
      rd_hs = rd_valid && rd_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (wr_hs) widx++;
      if (rd_hs) hs++;
      if (cyc == 1) begin
        check_eq("busy_after_start", 64'(busy), 64'(s <= e));
        if (s <= e) check_eq("timeout_cleared", 64'(timeout_err), 64'd0);
      end
      if (abort_after > 0 && hs >= abort_after) mode = MODE_IDLE;
      if (done) begin
        seen = 1'b1;
        mode = MODE_IDLE;
        check_eq("busy_at_done", 64'(busy), 64'd0);
      end
      if (rdy_len > 0 && cyc == rdy_at) snap = ram_addr;
      if (rdy_len > 0 && cyc == rdy_at + rdy_len) check_eq("ptr_frozen", 64'(ram_addr), 64'(snap));
      ram_rdy = !(cyc >= rdy_at && cyc < rdy_at + rdy_len);
      if (rr_len > 0 && cyc == rr_at + rr_len) begin
        check_eq("rd_valid_held", 64'(rd_valid), 64'd1);
        if (hs < exp_rd.size()) check_eq("rd_data_held", 64'(rd_data), 64'(exp_rd[hs]));
      end
      if (cyc >= rr_at && cyc < rr_at + rr_len) rd_ready = 1'b0;
      else rd_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_valid = (widx < src.size()) && ($urandom_range(0, 3) != 0);
      wr_data  = (widx < src.size()) ? src[widx] : '0;
    end
    check_eq("done_seen", 64'(seen), 64'd1);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    ram_rdy  = 1'b1;
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("busy_idle", 64'(busy), 64'd0);
    rdy_len = 0;
    rr_len = 0;
    rr_rand = 1'b0;
  endtask

  task automatic check_wr(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
    int n;
    logic [ADDR_W-1:0] a;
    n = int'(e - s) + 1;
    check_eq("wr_count", 64'(wr_addr_log.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
      a = s + ADDR_W'(i);
      check_eq("wr_addr", 64'(wr_addr_log[i]), 64'(a));
      check_eq("wr_data", 64'(wr_data_log[i]), 64'(ref_mem[a]));
    end
    check_eq("wr_done_pulses", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_rd();
    check_eq("rd_count", 64'(rd_log.size()), 64'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) begin
      check_eq("rd_data", 64'(rd_log[i]), 64'(exp_rd[i]));
    end
    check_eq("rd_req_count", 64'(req_cnt), 64'(exp_rd.size()));
    check_eq("rd_ack_count", 64'(ack_cnt), 64'(exp_rd.size()));
    check_eq("rd_done_pulses", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    logic [ADDR_W-1:0] amax;
    bit got_req;
    amax = '1;
    reset_n = 1'b0;
    mode = MODE_IDLE;
    start_addr = '0;
    end_addr = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_ready = 1'b0;
    ram_rdy = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_status", 64'({busy, done, timeout_err, wr_ready, rd_valid}), 64'd0);
    check_eq("rst_ram_ctl", 64'({ram_we, ram_rd_req, ram_rd_ack}), 64'd0);
    check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_data", 64'({ram_din, rd_data}), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_status", 64'({busy, done, wr_ready, rd_valid}), 64'd0);

    // Record A1..D4 into 0x10..0x13.
    src = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) ref_mem[ADDR_W'(32'h10 + i)] = src[i];
    session(MODE_REC, 26'h10, 26'h13, 0, 200);
    check_wr(26'h10, 26'h13);

    // Playback with 3-cycle read latency.
    rd_lat = 3;
    fill_exp(26'h10, 26'h13, 4);
    session(MODE_PLAY, 26'h10, 26'h13, 0, 200);
    check_rd();

    // Loop playback, stopped right after the 5th sample.
    rd_lat = 2;
    fill_exp(26'h10, 26'h11, 5);
    session(MODE_LOOP, 26'h10, 26'h11, 5, 300);
    check_rd();

    // Read timeout: no ram_rd_pres ever.
    rsp_block = 1'b1;
    exp_rd.delete();
    session(MODE_PLAY, 26'h20, 26'h20, 0, 100);
    check_eq("timeout_err_set", 64'(timeout_err), 64'd1);
    check_eq("timeout_latency", 64'(last_done_cyc - last_req_cyc), 64'd9);
    check_eq("timeout_no_ack", 64'(ack_cnt), 64'd0);
    rsp_block = 1'b0;

    // Record with a 4-cycle ram_rdy drop, then playback with a 6-cycle rd_ready hold.
    prep_rec(26'h40, 8);
    rdy_at = 4;
    rdy_len = 4;
    session(MODE_REC, 26'h40, 26'h47, 0, 300);
    check_wr(26'h40, 26'h47);
    rd_lat = 3;
    fill_exp(26'h40, 26'h47, 8);
    rr_at = 8;
    rr_len = 6;
    rr_rand = 1'b1;
    session(MODE_PLAY, 26'h40, 26'h47, 0, 400);
    check_rd();

    // Empty region (start > end) is ignored.
    src.delete();
    session(MODE_REC, 26'h5, 26'h4, 0, 20);
    check_eq("ignored_no_writes", 64'(wr_addr_log.size()), 64'd0);
    check_eq("ignored_done_pulses", 64'(done_cnt), 64'd1);

    // Top-of-address-space region must not wrap to address 0.
    prep_rec(amax - ADDR_W'(1), 2);
    session(MODE_REC, amax - ADDR_W'(1), amax, 0, 100);
    check_wr(amax - ADDR_W'(1), amax);
    rd_lat = 1;
    fill_exp(amax - ADDR_W'(1), amax, 2);
    session(MODE_PLAY, amax - ADDR_W'(1), amax, 0, 100);
    check_rd();

    // Reset while waiting for read data.
    rsp_block = 1'b1;
    ack_cnt = 0;
    @(posedge clk);
    #1;
    mode = MODE_PLAY;
    start_addr = 26'h60;
    end_addr = 26'h60;
    got_req = 1'b0;
    for (int k = 0; k < 20 && !got_req; k++) begin
      @(posedge clk);
      #1;
      if (ram_rd_req) got_req = 1'b1;
    end
    check_eq("rst_test_req_seen", 64'(got_req), 64'd1);
    check_eq("rst_test_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("midrst_ctl", 64'({ram_we, ram_rd_req, ram_rd_ack, rd_valid, done, timeout_err}),
             64'd0);
    check_eq("midrst_data", 64'({ram_din, rd_data}), 64'd0);
    mode = MODE_IDLE;
    rsp_block = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_eq("midrst_no_ack", 64'(ack_cnt), 64'd0);
    prep_rec(26'h50, 1);
    session(MODE_REC, 26'h50, 26'h50, 0, 50);
    check_wr(26'h50, 26'h50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
